// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the integer register file with scoreboard.
// Carries the default widths, the register/address bus types, the all-zero
// data word and the saturation limit of a pending-write counter.
package regfile_sb_pkg;

  localparam int unsigned DEF_XLEN   = 64;
  localparam int unsigned DEF_NREG   = 32;
  localparam int unsigned DEF_CNT_W  = 2;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [DEF_XLEN-1:0]   reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t ZERO_WORD = '0;

  // Largest value a cnt_w-bit pending-write counter may hold.
  function automatic int unsigned sb_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  localparam int unsigned SB_MAX = sb_max(DEF_CNT_W);

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file.
// One CNT_W-bit counter per architectural register counts writes issued but
// not yet written back. Counter 0 never moves (x0 is never written).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   w_ena, w_addr        write-back valid / destination (retires one pending write)
//   r1_ena/r1_addr       read port 1 lookup  -> r1_busy
//   r2_ena/r2_addr       read port 2 lookup  -> r2_busy
//   issue_ena, issue_rd  decode issue request -> issue_ready
//   flush                clears every counter at the next edge
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_ena,
  input  logic [4:0] w_addr,
  input  logic       r1_ena,
  input  logic [4:0] r1_addr,
  output logic       r1_busy,
  input  logic       r2_ena,
  input  logic [4:0] r2_addr,
  output logic       r2_busy,
  input  logic       issue_ena,
  input  logic [4:0] issue_rd,
  output logic       issue_ready,
  input  logic       flush
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sb_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic             inc;
  logic             dec;

  // A register is busy unless its only pending write is being written back
  // right now; in that case the bypass path already supplies the value.
  function automatic logic busy_of(input logic             ena,
                                   input logic [4:0]       addr,
                                   input logic [CNT_W-1:0] cnt,
                                   input logic             wb_ena,
                                   input logic [4:0]       wb_addr);
    return ena & (addr != '0) & (cnt != '0)
         & ~(wb_ena & (wb_addr == addr) & (cnt == CNT_ONE));
  endfunction

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    issue_ready = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    r1_busy     = 1'b0;
    r2_busy     = 1'b0;
    // A saturated counter blocks issue even if a write-back to the same
    // register lands this cycle; keeps the ready path short.
    issue_ready = ~rst & ((issue_rd == '0) | (cnt_q[issue_rd] != CNT_MAX));
    inc         = issue_ena & issue_ready & (issue_rd != '0);
    dec         = w_ena & (w_addr != '0) & (cnt_q[w_addr] != '0);
    r1_busy     = busy_of(r1_ena, r1_addr, cnt_q[r1_addr], w_ena, w_addr);
    r2_busy     = busy_of(r2_ena, r2_addr, cnt_q[r2_addr], w_ena, w_addr);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every reader in the same edge sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      // Index 0 is skipped: it is only ever written by reset/flush to zero.
      for (int i = 1; i < NREG; i++) begin
        if (inc && (issue_rd == 5'(i)) && !(dec && (w_addr == 5'(i))))
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        else if (dec && (w_addr == 5'(i)) && !(inc && (issue_rd == 5'(i))))
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with scoreboard: receiving end of the write-back path.
// Holds NREG x XLEN registers (x0 hardwired to zero), serves two zero-latency
// read ports with same-cycle write-to-read bypass, and tracks pending writes
// per register so decode can stall on RAW hazards.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   w_ena/w_addr/w_data      write-back port
//   r1_ena/r1_addr           read port 1 -> r1_data, r1_busy
//   r2_ena/r2_addr           read port 2 -> r2_data, r2_busy
//   issue_ena/issue_rd       decode issue -> issue_ready
//   flush                    clears all pending-write counters
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = DEF_NREG,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_ena,
  input  logic [4:0]      w_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic            r1_ena,
  input  logic [4:0]      r1_addr,
  output logic [XLEN-1:0] r1_data,
  output logic            r1_busy,
  input  logic            r2_ena,
  input  logic [4:0]      r2_addr,
  output logic [XLEN-1:0] r2_data,
  output logic            r2_busy,
  input  logic            issue_ena,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            flush
);

  logic [XLEN-1:0] regs_q [NREG];

  // NOTE: the data array is reset because architectural state must read 0
  // after reset; this rules out a plain RAM macro for this array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= ZERO_WORD;
    end else if (w_ena && (w_addr != '0)) begin
      regs_q[w_addr] <= w_data;
    end
  end

  // Read mux: x0 and disabled ports give zero; a same-cycle write-back wins
  // over the stored value. Reset is gated in so w_data cannot leak through.
  function automatic logic [XLEN-1:0] read_port(input logic            ena,
                                                input logic [4:0]      addr,
                                                input logic [XLEN-1:0] stored);
    if (rst || !ena || (addr == '0)) return ZERO_WORD;
    if (w_ena && (w_addr == addr))   return w_data;
    return stored;
  endfunction

  always_comb begin
    r1_data = ZERO_WORD;
    r2_data = ZERO_WORD;
    r1_data = read_port(r1_ena, r1_addr, regs_q[r1_addr]);
    r2_data = read_port(r2_ena, r2_addr, regs_q[r2_addr]);
  end

  reg_scoreboard #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .w_ena       (w_ena),
    .w_addr      (w_addr),
    .r1_ena      (r1_ena),
    .r1_addr     (r1_addr),
    .r1_busy     (r1_busy),
    .r2_ena      (r2_ena),
    .r2_addr     (r2_addr),
    .r2_busy     (r2_busy),
    .issue_ena   (issue_ena),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register file
// (plain arrays of values and pending-write counts).
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        r1_ena, r2_ena;
  logic [4:0]  r1_addr, r2_addr;
  logic [63:0] r1_data, r2_data;
  logic        r1_busy, r2_busy;
  logic        issue_ena;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [63:0] m_reg [32];
  int          m_cnt [32];

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .w_ena       (w_ena),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .r1_ena      (r1_ena),
    .r1_addr     (r1_addr),
    .r1_data     (r1_data),
    .r1_busy     (r1_busy),
    .r2_ena      (r2_ena),
    .r2_addr     (r2_addr),
    .r2_data     (r2_data),
    .r2_busy     (r2_busy),
    .issue_ena   (issue_ena),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
  endfunction

  // Value a decode read should see: x0/disabled -> 0, in-flight write-back
  // forwarded, otherwise the architectural value.
  function automatic logic [63:0] exp_data(input logic e, input logic [4:0] a);
    if (rst || !e || a == 0) return '0;
    if (w_ena && w_addr == a) return w_data;
    return m_reg[a];
  endfunction

  // Busy when writes are still outstanding after this cycle's write-back.
  function automatic logic exp_busy(input logic e, input logic [4:0] a);
    int remaining;
    if (rst || !e || a == 0) return 1'b0;
    remaining = m_cnt[a];
    if (w_ena && w_addr == a && remaining == 1) remaining = 0;
    return remaining > 0;
  endfunction

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    return issue_rd == 0 || m_cnt[issue_rd] < int'(SB_MAX);
  endfunction

  task automatic apply(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2,
                       input logic ie, input logic [4:0] ird, input logic fl);
    w_ena = we; w_addr = wa; w_data = wd;
    r1_ena = e1; r1_addr = a1; r2_ena = e2; r2_addr = a2;
    issue_ena = ie; issue_rd = ird; flush = fl;
    #2;
    if (rst) model_clear();
    check("r1_data", r1_data, exp_data(e1, a1));
    check("r2_data", r2_data, exp_data(e2, a2));
    check("r1_busy", 64'(r1_busy), 64'(exp_busy(e1, a1)));
    check("r2_busy", 64'(r2_busy), 64'(exp_busy(e2, a2)));
    check("issue_ready", 64'(issue_ready), 64'(exp_ready()));
  endtask

  task automatic tick();
    int inc, dec;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      inc = (issue_ena && issue_rd != 0 && m_cnt[issue_rd] < int'(SB_MAX)) ? 1 : 0;
      dec = (w_ena && w_addr != 0 && m_cnt[w_addr] > 0) ? 1 : 0;
      if (w_ena && w_addr != 0) m_reg[w_addr] = w_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
        m_cnt[issue_rd] += inc;
        m_cnt[w_addr]   -= dec;
      end
    end
    #1;
  endtask

  task automatic idle();
    apply(0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [63:0] v;
    rst = 1'b1;
    model_clear();
    // Reset active: outputs must be zero even with a write-back and issue present.
    apply(1, 5, 64'h1111, 1, 5, 1, 5, 1, 5, 0);
    check("rst_issue_ready", 64'(issue_ready), 64'd0);
    tick();
    rst = 1'b0;

    // Write-back then read next cycle; reset wipes it.
    apply(1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    tick();
    apply(0, 0, '0, 1, 5, 0, 0, 0, 0, 0);
    check("x5_after_wb", r1_data, 64'hDEAD_BEEF);
    tick();
    rst = 1'b1;
    apply(0, 0, '0, 1, 5, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    apply(0, 0, '0, 1, 5, 0, 0, 0, 0, 0);
    check("x5_after_rst", r1_data, 64'd0);
    check("x5_busy_after_rst", 64'(r1_busy), 64'd0);
    tick();

    // Same-cycle bypass on both ports.
    apply(1, 3, 64'h1234, 1, 3, 1, 3, 0, 0, 0);
    check("bypass_r1", r1_data, 64'h1234);
    check("bypass_r2", r2_data, 64'h1234);
    tick();

    // x0 is hardwired: writes ignored, issues to rd=0 never tracked.
    apply(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, '0, 1, 0, 0, 0, 1, 0, 0);
      check("x0_ready", 64'(issue_ready), 64'd1);
      check("x0_data", r1_data, 64'd0);
      tick();
    end

    // Two pending writes to x7; only the last write-back clears busy.
    apply(0, 0, '0, 0, 0, 0, 0, 1, 7, 0); tick();
    apply(0, 0, '0, 0, 0, 0, 0, 1, 7, 0); tick();
    apply(0, 0, '0, 1, 7, 0, 0, 0, 0, 0);
    check("x7_busy_two", 64'(r1_busy), 64'd1);
    tick();
    apply(1, 7, 64'hA1, 1, 7, 0, 0, 0, 0, 0);
    check("x7_busy_one_left", 64'(r1_busy), 64'd1);
    tick();
    apply(1, 7, 64'hB2, 1, 7, 0, 0, 0, 0, 0);
    check("x7_busy_last_wb", 64'(r1_busy), 64'd0);
    check("x7_data_last_wb", r1_data, 64'hB2);
    tick();

    // Saturate x9; a same-cycle write-back does not unblock the issue.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, '0, 0, 0, 0, 0, 1, 9, 0);
      tick();
    end
    apply(0, 0, '0, 0, 0, 0, 0, 1, 9, 0);
    check("x9_saturated", 64'(issue_ready), 64'd0);
    apply(1, 9, 64'h99, 0, 0, 0, 0, 1, 9, 0);
    check("x9_sat_with_wb", 64'(issue_ready), 64'd0);
    tick();
    apply(0, 0, '0, 1, 9, 0, 0, 1, 9, 0);
    check("x9_ready_after", 64'(issue_ready), 64'd1);
    tick();

    // Flush with a concurrent write-back.
    apply(1, 6, 64'h66, 0, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, '0, 0, 0, 0, 0, 1, 4, 0); tick();
    apply(0, 0, '0, 0, 0, 0, 0, 1, 6, 0); tick();
    apply(1, 4, 64'h55, 0, 0, 0, 0, 0, 0, 1); tick();
    apply(0, 0, '0, 1, 4, 1, 6, 1, 9, 0);
    check("flush_x4_data", r1_data, 64'h55);
    check("flush_x6_data", r2_data, 64'h66);
    check("flush_x4_busy", 64'(r1_busy), 64'd0);
    check("flush_x6_busy", 64'(r2_busy), 64'd0);
    tick();

    // Random traffic, biased to a few registers so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, a1, a2, ird;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      a1  = 5'($urandom_range(0, 5));
      a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      ird = 5'($urandom_range(0, 5));
      v   = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      apply(1'($urandom_range(0, 1)), wa, v,
            1'($urandom_range(0, 7) != 0), a1,
            1'($urandom_range(0, 7) != 0), a2,
            1'($urandom_range(0, 2) != 0), ird,
            1'($urandom_range(0, 39) == 0));
      tick();
      rst = 1'b0;
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
